// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode and state encodings shared by the register-file sequencer
package ctrl_pkg;
  localparam logic [2:0] OP_RD_PAIR   = 3'd0;
  localparam logic [2:0] OP_RD_RESULT = 3'd1;
  localparam logic [2:0] OP_WR_RESULT = 3'd2;
  localparam logic [2:0] OP_WR_ERROR  = 3'd3;
  localparam logic [2:0] OP_RD_BURST  = 3'd4;
  typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;
endpackage

// File: rtl/ctrl_regf_addrgen.sv
// ctrl_regf_addrgen: builds {ch, base +/- off} with the index wrapping inside the channel window
module ctrl_regf_addrgen #(
  parameter int AW = 3,
  parameter int CW = 1
) (
  input  logic [CW-1:0]    ch,
  input  logic [AW-1:0]    base,
  input  logic [AW-1:0]    off,
  input  logic             sub,
  output logic [CW+AW-1:0] addr
);
  always_comb addr = {ch, sub ? base - off : base + off};
endmodule

// File: rtl/ctrl_regfseq.sv
// ctrl_regfseq: register-file address sequencer; one valid/ready command in, registered ar1/ar2 read and ard write beats out
module ctrl_regfseq
  import ctrl_pkg::*;
#(
  parameter int AW = 3,
  parameter int NCH = 2,
  parameter int LENW = 4,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CW-1:0]    cmd_ch,
  input  logic [LENW-1:0]  cmd_len,
  input  logic [AW-1:0]    result_reg,
  input  logic [AW-1:0]    error_reg,
  output logic [CW+AW-1:0] ar1,
  output logic             ar1_vld,
  output logic [CW+AW-1:0] ar2,
  output logic             ar2_vld,
  output logic [CW+AW-1:0] ard,
  output logic             ard_we,
  output logic             busy,
  output logic             done
);
  state_t state, state_d;
  logic [LENW-1:0] k, k_d, len_q, len_d, len_s, k_s;
  logic [2:0] op_q, op_d, op_s;
  logic [CW-1:0] ch_q, ch_d, ch_s, ch_in;
  logic [AW-1:0] rr_q, rr_d, rr_s, er_q, er_d, er_s;
  logic [CW+AW-1:0] a1, a2, ar1_d, ar2_d, ard_d;
  logic ar1_vld_d, ar2_vld_d, ard_we_d, done_d;
  logic last_beat, acc, beat, rd1, rd2, wr;
  // Beat sources: a freshly accepted command starts at k=0, otherwise the captured burst advances
  always_comb begin
    last_beat = (state == ISSUE) | (state == BURST & k == len_q);
    cmd_ready = en & ~rst & (state == IDLE | last_beat);
    acc = cmd_valid & cmd_ready;
    busy = state != IDLE;
    ch_in = ({1'b0, cmd_ch} >= (CW+1)'(NCH)) ? CW'(NCH - 1) : cmd_ch;
    op_s = acc ? cmd_op : op_q;
    ch_s = acc ? ch_in : ch_q;
    rr_s = acc ? result_reg : rr_q;
    er_s = acc ? error_reg : er_q;
    len_s = acc ? cmd_len : len_q;
    k_s = acc ? '0 : k + 1'b1;
    beat = acc | (state == BURST & ~last_beat);
    rd1 = beat & (op_s == OP_RD_PAIR | op_s == OP_RD_RESULT | op_s == OP_RD_BURST);
    rd2 = beat & (op_s == OP_RD_PAIR | op_s == OP_RD_BURST);
    wr = beat & (op_s == OP_WR_RESULT | op_s == OP_WR_ERROR);
    state_d = acc ? (cmd_op == OP_RD_BURST ? BURST : ISSUE) : (beat ? BURST : IDLE);
    k_d = beat ? k_s : k;
    op_d = op_s;
    ch_d = ch_s;
    rr_d = rr_s;
    er_d = er_s;
    len_d = len_s;
    ar1_d = beat ? (rd1 ? a1 : '0) : ar1;
    ar2_d = beat ? (rd2 ? a2 : '0) : ar2;
    ard_d = beat ? (wr ? {ch_s, op_s == OP_WR_RESULT ? rr_s : er_s} : '0) : ard;
    ar1_vld_d = rd1;
    ar2_vld_d = rd2;
    ard_we_d = wr;
    done_d = beat & (op_s != OP_RD_BURST | k_s == len_s);
  end
  ctrl_regf_addrgen #(.AW(AW), .CW(CW)) u_ar1 (
    .ch(ch_s), .base(rr_s), .off(op_s == OP_RD_PAIR ? AW'(1) : AW'(k_s)), .sub(1'b1), .addr(a1)
  );
  ctrl_regf_addrgen #(.AW(AW), .CW(CW)) u_ar2 (
    .ch(ch_s), .base(er_s), .off(AW'(k_s)), .sub(1'b0), .addr(a2)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      len_q <= '0;
      op_q <= '0;
      ch_q <= '0;
      rr_q <= '0;
      er_q <= '0;
      ar1 <= '0;
      ar2 <= '0;
      ard <= '0;
      ar1_vld <= 1'b0;
      ar2_vld <= 1'b0;
      ard_we <= 1'b0;
      done <= 1'b0;
    end else if (en) begin
      state <= state_d;
      k <= k_d;
      len_q <= len_d;
      op_q <= op_d;
      ch_q <= ch_d;
      rr_q <= rr_d;
      er_q <= er_d;
      ar1 <= ar1_d;
      ar2 <= ar2_d;
      ard <= ard_d;
      ar1_vld <= ar1_vld_d;
      ar2_vld <= ar2_vld_d;
      ard_we <= ard_we_d;
      done <= done_d;
    end
  end
endmodule
